// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: cbus responder serving single/burst reads and writes from an internal word memory
// Ports: i_clk, i_resetn (async active-low); i_creq_* flattened cbus request
// (valid, is_write, size, addr, strobe, data, len = beats-1); o_cresp_* response (ready, last, data).
// Optional: define CBUS_MEM_STALL_EN to insert pseudo-random stall cycles from an 8-bit LFSR.
module cbus_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_creq_valid,
  input  logic        i_creq_is_write,
  input  logic [1:0]  i_creq_size,
  input  logic [31:0] i_creq_addr,
  input  logic [3:0]  i_creq_strobe,
  input  logic [31:0] i_creq_data,
  input  logic [3:0]  i_creq_len,
  output logic        o_cresp_ready,
  output logic        o_cresp_last,
  output logic [31:0] o_cresp_data
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
  localparam int AW = MEM_WORDS_LOG2;
  state_t r_state, w_next;
  logic [AW-1:0] r_base, w_req_idx, w_beat_idx, w_rd_idx;
  logic [3:0] r_len, r_cnt;
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;
  logic w_active, w_stall, w_ready, w_last, w_accept, w_rd_en, w_wr_en;
  // size and the address bits outside the word index play no part in addressing
  logic w_unused;
  assign w_unused = ^{i_creq_size, i_creq_addr[31:AW+2], i_creq_addr[1:0]};
`ifdef CBUS_MEM_STALL_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) r_lfsr <= 8'hA5;
    else r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_stall = r_lfsr[1:0] == 2'b00;
`else
  assign w_stall = 1'b0;
`endif
  assign w_active   = r_state != S_IDLE;
  assign w_ready    = w_active && !w_stall;
  assign w_last     = w_ready && r_cnt == r_len;
  assign w_accept   = r_state == S_IDLE && i_creq_valid;
  assign w_req_idx  = i_creq_addr[AW+1:2];
  assign w_beat_idx = r_base + AW'(r_cnt);
  // reads run one index ahead of the beat being returned; a stall re-reads the current index
  assign w_rd_idx   = w_active ? w_beat_idx + AW'(w_ready) : w_req_idx;
  assign w_rd_en    = (w_accept && !i_creq_is_write) || r_state == S_RD;
  // a dropped valid aborts the burst, so the beat in flight must not commit
  assign w_wr_en    = r_state == S_WR && w_ready && i_creq_valid;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = i_creq_is_write ? S_WR : S_RD;
    else if (w_active && (!i_creq_valid || w_last)) w_next = S_IDLE;
  end
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base <= w_req_idx;
        r_len  <= i_creq_len;
      end
      r_cnt <= !w_active ? 4'd0 : r_cnt + 4'(w_ready);
    end
  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      for (int k = 0; k < 4; k++)
        if (i_creq_strobe[k]) r_mem[w_beat_idx][8*k +: 8] <= i_creq_data[8*k +: 8];
    if (w_rd_en) r_rdata <= r_mem[w_rd_idx];
  end
  assign o_cresp_ready = w_ready;
  assign o_cresp_last  = w_last;
  assign o_cresp_data  = (r_state == S_RD && w_ready) ? r_rdata : 32'h0;
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed self-checking bench for cbus_mem_responder
module tb_cbus_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_write = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  strobe = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  len = '0;
  logic        ready, last;
  logic [31:0] rdata;
  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];
  int checks = 0;
  int failures = 0;

  cbus_mem_responder dut (
    .i_clk(clk), .i_resetn(rst_n), .i_creq_valid(valid), .i_creq_is_write(is_write),
    .i_creq_size(size), .i_creq_addr(addr), .i_creq_strobe(strobe), .i_creq_data(wdata),
    .i_creq_len(len), .o_cresp_ready(ready), .o_cresp_last(last), .o_cresp_data(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // drop >= 0 deasserts valid once that many beats have completed
  task automatic burst(input logic wr, input logic [31:0] a, input logic [3:0] ln,
                       input logic [3:0] st, input int drop);
    int b = 0;
    int cyc = 0;
    @(negedge clk);
    valid = 1'b1; is_write = wr; addr = a; len = ln; strobe = st; wdata = wbuf[0];
    chk("req_cycle_rdy", ready, 0);
    while (b <= int'(ln) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (b == drop) begin
        valid = 1'b0;
        @(negedge clk);
        chk("abort_rdy", ready, 0);
        return;
      end
      wdata = wbuf[b];
`ifndef CBUS_MEM_STALL_EN
      chk("beat_rdy", ready, 1);
`endif
      if (ready) begin
        chk("beat_last", last, b == int'(ln));
        chk("beat_data", rdata, wr ? 32'h0 : rexp[b]);
        b++;
      end else begin
        chk("stall_last", last, 0);
        chk("stall_data", rdata, 0);
      end
    end
    if (cyc >= 200) chk("timeout", cyc, 0);
    @(negedge clk);
    valid = 1'b0;
    chk("gap_rdy", ready, 0);
    chk("gap_last", last, 0);
  endtask

  initial begin
    #12;
    chk("rst_rdy", ready, 0);
    chk("rst_last", last, 0);
    chk("rst_data", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wbuf[0] = 32'hDEADBEEF;
    burst(1'b1, 32'h100, 4'd0, 4'b1111, -1);
    rexp[0] = 32'hDEADBEEF;
    burst(1'b0, 32'h100, 4'd0, 4'b1111, -1);
    wbuf[0] = 32'hAAAAAAAA;
    burst(1'b1, 32'h104, 4'd0, 4'b1111, -1);
    wbuf[0] = 32'h11223344;
    burst(1'b1, 32'h104, 4'd0, 4'b0101, -1);
    rexp[0] = 32'hAA22AA44;
    burst(1'b0, 32'h104, 4'd0, 4'b0000, -1);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
    burst(1'b1, 32'h200, 4'd3, 4'b1111, -1);
    burst(1'b0, 32'h200, 4'd3, 4'b0000, -1);
    for (int i = 0; i < 14; i++) wbuf[i] = 32'hC000 + 32'(i);
    burst(1'b1, 32'h0, 4'd13, 4'b1111, -1);
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
    burst(1'b1, 32'h3FF8, 4'd1, 4'b1111, -1);
    rexp[0] = 32'hE0; rexp[1] = 32'hE1;
    for (int i = 0; i < 14; i++) rexp[i + 2] = 32'hC000 + 32'(i);
    burst(1'b0, 32'h8000_3FF8, 4'd15, 4'b0000, -1);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    burst(1'b1, 32'h300, 4'd3, 4'b1111, -1);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
    burst(1'b1, 32'h300, 4'd3, 4'b1111, 2);
    rexp[0] = 32'hB0; rexp[1] = 32'hB1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    burst(1'b0, 32'h300, 4'd3, 4'b0000, -1);
    @(negedge clk);
    valid = 1'b1; is_write = 1'b0; addr = 32'h0; len = 4'd15;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", ready, 0);
    chk("async_rst_last", last, 0);
    chk("async_rst_data", rdata, 0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rexp[0] = 32'hDEADBEEF;
    burst(1'b0, 32'h100, 4'd0, 4'b0000, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
